// File: rtl/counter_modulo_down.sv
// Modulo-N down counter with clamped parallel load, terminal count for cascading,
// a registered borrow pulse on each wrap and a saturating 16-bit wrap counter.
module counter_modulo_down #(
  parameter int unsigned MODULO = 7,
  parameter int          WIDTH  = $clog2(MODULO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             tc,
  output logic             borrow,
  output logic [15:0]      wraps
);

  if (MODULO < 2 || MODULO > 65536) begin : g_bad_modulo
    $error("counter_modulo_down: MODULO must be in 2..65536");
  end

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULO - 1);
  localparam logic [15:0]      WRAPS_SAT = 16'hFFFF;

  logic [WIDTH-1:0] load_val;
  logic             wrap;

  // Out-of-range load values clamp to the top of the range so the count never leaves 0..MODULO-1.
  assign load_val = (32'(din) < MODULO) ? din : MAX_COUNT;

  assign zero = (out == '0);
  assign tc   = zero && ce && !load;
  assign wrap = tc;

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      out    <= MAX_COUNT;
      borrow <= 1'b0;
      wraps  <= '0;
    end else begin
      borrow <= wrap;
      if (load) begin
        out <= load_val;
      end else if (ce) begin
        out <= zero ? MAX_COUNT : out - WIDTH'(1);
      end
      if (wrap && (wraps != WRAPS_SAT)) begin
        wraps <= wraps + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_counter_modulo_down.sv
// Directed self-checking bench for counter_modulo_down with MODULO=7.
module tb_counter_modulo_down;

  localparam int unsigned MODULO = 7;
  localparam int          WIDTH  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             ce;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             tc;
  logic             borrow;
  logic [15:0]      wraps;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  counter_modulo_down #(.MODULO(MODULO), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .load   (load),
    .din    (din),
    .out    (out),
    .zero   (zero),
    .tc     (tc),
    .borrow (borrow),
    .wraps  (wraps)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled one falling edge later.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    int exp_out;

    rst  = 1'b1;
    ce   = 1'b1;
    load = 1'b0;
    din  = '0;

    // Reset held for two edges, with ce high to show reset wins.
    cyc();
    cyc();
    check("rst_out", 32'(out), 32'd6);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_tc", 32'(tc), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_wraps", 32'(wraps), 32'd0);

    // Free run: 6,5,4,3,2,1,0,6,... for 21 enabled cycles.
    rst = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      cyc();
      exp_out = (6 - (k % 7) + 7) % 7;
      check("run_out", 32'(out), 32'(exp_out));
      check("run_tc", 32'(tc), (exp_out == 0) ? 32'd1 : 32'd0);
      check("run_borrow", 32'(borrow), (k % 7 == 0) ? 32'd1 : 32'd0);
    end
    check("run_wraps", 32'(wraps), 32'd3);

    // Parallel load: in-range, clamped, and load of 0 followed by a wrap.
    ce = 1'b0; load = 1'b1; din = 3'd3;
    cyc();
    check("load3_out", 32'(out), 32'd3);
    check("load3_borrow", 32'(borrow), 32'd0);
    din = 3'd7;
    cyc();
    check("load7_clamp", 32'(out), 32'd6);
    ce = 1'b1; din = 3'd0;
    cyc();
    check("load0_out", 32'(out), 32'd0);
    check("load0_zero", 32'(zero), 32'd1);
    check("load0_tc_masked", 32'(tc), 32'd0);
    load = 1'b0;
    #1;
    check("load0_tc", 32'(tc), 32'd1);
    cyc();
    check("load0_wrap_out", 32'(out), 32'd6);
    check("load0_wrap_borrow", 32'(borrow), 32'd1);
    check("load0_wrap_wraps", 32'(wraps), 32'd4);

    // ce gating: enabled on even steps only; reaches 0 after 6 enabled cycles.
    for (int i = 0; i < 12; i++) begin
      ce = (i % 2 == 0);
      cyc();
      check("gate_out", 32'(out), 32'(6 - (i / 2 + 1)));
      check("gate_borrow", 32'(borrow), 32'd0);
    end
    check("gate_tc_ce0", 32'(tc), 32'd0);
    check("gate_wraps", 32'(wraps), 32'd4);

    // Load colliding with a would-be wrap: load wins, no borrow, no wrap counted.
    ce = 1'b1; load = 1'b1; din = 3'd4;
    #1;
    check("coll_tc", 32'(tc), 32'd0);
    cyc();
    check("coll_out", 32'(out), 32'd4);
    check("coll_borrow", 32'(borrow), 32'd0);
    check("coll_wraps", 32'(wraps), 32'd4);
    load = 1'b0;

    // Reset mid-count, asserted in the same cycle a wrap would occur.
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("pre_rst_out", 32'(out), 32'(3 - i));
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("mid_rst_out", 32'(out), 32'd6);
      check("mid_rst_borrow", 32'(borrow), 32'd0);
      check("mid_rst_wraps", 32'(wraps), 32'd0);
      check("mid_rst_zero", 32'(zero), 32'd0);
      check("mid_rst_tc", 32'(tc), 32'd0);
    end
    rst = 1'b0;
    cyc();
    check("post_rst_out0", 32'(out), 32'd5);
    cyc();
    check("post_rst_out1", 32'(out), 32'd4);

    // Saturation: preset the wrap counter just below full, then keep wrapping.
    force dut.wraps = 16'hFFFD;
    #1;
    release dut.wraps;
    #1;
    check("sat_preset", 32'(wraps), 32'h0000FFFD);
    for (int k = 1; k <= 19; k++) begin
      cyc();
      check("sat_borrow", 32'(borrow), (k == 5 || k == 12 || k == 19) ? 32'd1 : 32'd0);
      check("sat_wraps", 32'(wraps), (k < 5) ? 32'h0000FFFD : (k < 12) ? 32'h0000FFFE : 32'h0000FFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_modulo_down.md
COUNTER_MODULO_DOWN -- requirements
Module: counter_modulo_down

Interface
REQ-001 SHALL have parameter MODULO, default 7: count range 0..MODULO-1, legal values 2..65536.
REQ-002 SHALL have parameter WIDTH, default $clog2(MODULO): width of the count ports.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port ce, input, 1 bit: count enable.
REQ-006 SHALL have port load, input, 1 bit: parallel-load strobe.
REQ-007 SHALL have port din, input, WIDTH bits: parallel-load value.
REQ-008 SHALL have port out, output, WIDTH bits: current count, registered.
REQ-009 SHALL have port zero, output, 1 bit: out == 0, combinational from the count register.
REQ-010 SHALL have port tc, output, 1 bit: terminal count, combinational (out == 0) && ce && !load, for cascading.
REQ-011 SHALL have port borrow, output, 1 bit: registered one-cycle pulse marking a wrap.
REQ-012 SHALL have port wraps, output, 16 bits: registered, saturating count of wrap events.

Function
REQ-013 SHALL apply per-cycle priority: rst > load > ce > hold.
REQ-014 SHALL, on load=1: set out <= din when din < MODULO, else out <= MODULO-1 (clamp); load ignores ce.
REQ-015 SHALL, on load=0, ce=1, out > 0: set out <= out - 1.
REQ-016 SHALL, on load=0, ce=1, out == 0: set out <= MODULO-1 (wrap); this is the only wrap event.
REQ-017 SHALL, on load=0, ce=0: hold out, wraps; borrow <= 0.
REQ-018 SHALL set borrow <= 1 in the cycle after a wrap event, otherwise borrow <= 0; a load never produces borrow.
REQ-019 SHALL increment wraps by 1 per wrap event, saturate at 16'hFFFF, and never wrap past it.
REQ-020 SHALL keep out within 0..MODULO-1 at all times, including for non-power-of-two MODULO.
REQ-021 SHALL produce a wrap every MODULO enabled cycles with continuous ce=1; tc is high in exactly 1 of every MODULO such cycles.
REQ-022 SHALL, with load=1 and ce=1 while out == 0: perform the load, produce no wrap, keep tc=0 and borrow=0 next cycle.
REQ-023 SHALL allow load of 0 with ce=1 on the next cycle, giving a wrap on that next cycle.
REQ-024 SHALL have no combinational path from din to any output.

Reset
REQ-025 SHALL, on rst=1 at a rising edge: out <= MODULO-1, borrow <= 0, wraps <= 0, regardless of ce and load.
REQ-026 SHALL, while rst is held: zero=0 and tc=0 (out = MODULO-1); counting resumes on the first edge with rst=0.
REQ-027 SHALL, on rst asserted mid-count or in the same cycle as a wrap: reset wins, borrow stays 0, wraps is cleared.

Verification (MODULO=7)
REQ-028 SHALL cover free run: rst for 2 cycles, then ce=1 -> out 6,5,4,3,2,1,0,6,...; tc high when out=0; borrow high one cycle after each 0->6 transition; wraps=3 after 21 enabled cycles.
REQ-029 SHALL cover load: load=1, din=3 -> out=3 next cycle; load with din=7 -> out=6 (clamp); load with din=0, ce=1 -> out=0, then 6 with borrow=1.
REQ-030 SHALL cover ce gating: ce toggled 1/0 every cycle from out=6 -> out changes only on enabled cycles, reaches 0 after 6 enabled cycles, and holds with borrow=0 while ce=0.
REQ-031 SHALL cover reset mid-operation: rst asserted at count cycle 20 and released at cycle 30 -> out=6, wraps=0, borrow=0 during reset; sequence restarts 6,5,... after release.
REQ-032 SHALL cover load/wrap collision: out=0, ce=1, load=1, din=4 -> out=4, borrow=0, wraps unchanged.
REQ-033 SHALL cover saturation: wraps forced near 16'hFFFE by a long run (or MODULO=2) -> wraps stops at 16'hFFFF while borrow keeps pulsing.
